// File: rtl/mash111_modulator_pkg.sv
// Shared types and constants for the MASH 1-1-1 modulator.
// Output code is a small signed integer formed by the noise-cancellation network.
package mash111_modulator_pkg;

    localparam int DOUT_W   = 4;
    localparam int DOUT_MIN = -3;
    localparam int DOUT_MAX = 4;

    typedef logic signed [DOUT_W-1:0] mash_code_t;

    // y = c1 + (1 - z^-1) c2 + (1 - z^-1)^2 c3, formed at code width.
    function automatic mash_code_t cancel_noise(
        input logic c1,
        input logic c2,
        input logic c2_d,
        input logic c3,
        input logic c3_d,
        input logic c3_dd
    );
        mash_code_t t1;
        mash_code_t t2;
        mash_code_t t2d;
        mash_code_t t3;
        mash_code_t t3d;
        mash_code_t t3dd;
        t1   = {{(DOUT_W-1){1'b0}}, c1};
        t2   = {{(DOUT_W-1){1'b0}}, c2};
        t2d  = {{(DOUT_W-1){1'b0}}, c2_d};
        t3   = {{(DOUT_W-1){1'b0}}, c3};
        t3d  = {{(DOUT_W-1){1'b0}}, c3_d};
        t3dd = {{(DOUT_W-1){1'b0}}, c3_dd};
        return t1 + (t2 - t2d) + (t3 - (t3d <<< 1) + t3dd);
    endfunction

endpackage

// File: rtl/mash111_modulator_if.sv
// Sample-in / code-out stream bundle between the CIC, the modulator and the DAC stage.
interface mash111_modulator_if #(
    parameter int WIDTH = 16
) ();
    import mash111_modulator_pkg::*;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    mash_code_t       dout;
    logic             dout_valid;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid
    );

endinterface

// File: rtl/mash111_modulator_accum_stage.sv
// One first-order error-feedback stage: WIDTH-bit accumulator whose carry is the stage output.
module mash_accum_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic             carry,
    output logic [WIDTH-1:0] residue
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, addend};
        carry   = sum[WIDTH];
        residue = sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= residue;
        end
    end

endmodule

// File: rtl/mash111_modulator.sv
// Third-order MASH 1-1-1 sigma-delta modulator with a double-buffered, held input sample.
// Each sample drives HOLD ticks; a swap with no fresh sample raises sticky underrun.
module mash111_modulator
    import mash111_modulator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int HOLD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_underrun,
    output logic                 underrun,
    mash111_modulator_if.slave   bus
);

    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] next_buf;
    logic             next_full;
    logic [HCW-1:0]   hold_cnt;
    logic             c2_d;
    logic             c3_d;
    logic             c3_dd;
    mash_code_t       dout_q;
    logic             dout_valid_q;
    logic             underrun_q;

    logic             c1, c2, c3;
    logic [WIDTH-1:0] e1, e2, e3;
    logic             ready;
    logic             accept;
    logic             swap;
    mash_code_t       y;

    mash_accum_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk(clk), .rst(rst), .en(en), .addend(cur), .carry(c1), .residue(e1)
    );

    mash_accum_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clk(clk), .rst(rst), .en(en), .addend(e1), .carry(c2), .residue(e2)
    );

    mash_accum_stage #(.WIDTH(WIDTH)) u_stage3 (
        .clk(clk), .rst(rst), .en(en), .addend(e2), .carry(c3), .residue(e3)
    );

    always_comb begin
        ready  = !next_full && !rst;
        accept = bus.din_valid && ready;
        swap   = en && (hold_cnt == HOLD_LAST);
        y      = cancel_noise(c1, c2, c2_d, c3, c3_d, c3_dd);
    end

    // e3 has no consumer beyond stage 3's own feedback.
    logic unused_e3;
    assign unused_e3 = ^e3;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= '0;
            next_buf     <= '0;
            next_full    <= 1'b0;
            hold_cnt     <= '0;
            c2_d         <= 1'b0;
            c3_d         <= 1'b0;
            c3_dd        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            if (accept) begin
                next_buf <= bus.din;
            end

            // A fill and a drain never coincide since ready is low while full.
            if (swap && next_full) begin
                next_full <= 1'b0;
                cur       <= next_buf;
            end else if (accept) begin
                next_full <= 1'b1;
            end

            if (swap && !next_full) begin
                underrun_q <= 1'b1;
            end else if (clr_underrun) begin
                underrun_q <= 1'b0;
            end

            dout_valid_q <= en;
            if (en) begin
                hold_cnt <= swap ? '0 : hold_cnt + HCW'(1);
                dout_q   <= y;
                c2_d     <= c2;
                c3_dd    <= c3_d;
                c3_d     <= c3;
            end
        end
    end

    assign bus.din_ready  = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign underrun       = underrun_q;

endmodule
